// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control bundles, hazard stall/flush,
// forwarding selects, saturating stall/flush counters. Define PIPE_CTRL_FWD_EN to enable forwarding.
module pipe_ctrl_unit #(
  parameter int ALUOP_W = 5,
  parameter int PCSRC_W = 4,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [5:0]         id_opcode,
  input  logic [5:0]         id_funcode,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               ex_redirect,
  output logic               pc_write_en,
  output logic               ifid_write_en,
  output logic               ifid_flush,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic [PCSRC_W-1:0] ex_pcsrc,
  output logic [1:0]         ex_fwd_a,
  output logic [1:0]         ex_fwd_b,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [RADDR_W-1:0] wb_dest,
  output logic               illegal_instr,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [ALUOP_W-1:0] d_alu_op;
  logic [PCSRC_W-1:0] d_pcsrc;
  logic [RADDR_W-1:0] d_dest;
  logic d_alu_src, d_mem_read, d_mem_write, d_reg_write, d_mem_to_reg, d_legal;

  logic [ALUOP_W-1:0] alu_op_p0;
  logic [PCSRC_W-1:0] pcsrc_p0;
  logic [RADDR_W-1:0] dest_p0, dest_p1, dest_p2;
  logic vld_p0, alu_src_p0, mr_p0, mw_p0, rw_p0, m2r_p0;
  logic vld_p1, mr_p1, mw_p1, rw_p1, m2r_p1;
  logic rw_p2, m2r_p2;
  logic hazard, stall, redirect, bubble_in;

  // ID: decode
  always_comb begin
    d_alu_op = '0; d_alu_src = 1'b0; d_pcsrc = '0; d_mem_read = 1'b0; d_mem_write = 1'b0;
    d_reg_write = 1'b0; d_mem_to_reg = 1'b0; d_dest = '0; d_legal = 1'b1;
    case (id_opcode)
      6'h00: begin
        d_dest = id_rd;
        d_reg_write = 1'b1;
        case (id_funcode)
          6'h20, 6'h21: d_alu_op = ALUOP_W'(0);
          6'h22, 6'h23: d_alu_op = ALUOP_W'(1);
          6'h24: d_alu_op = ALUOP_W'(2);
          6'h25: d_alu_op = ALUOP_W'(3);
          6'h27: d_alu_op = ALUOP_W'(4);
          6'h00: d_alu_op = ALUOP_W'(5);
          6'h02: d_alu_op = ALUOP_W'(6);
          6'h03: d_alu_op = ALUOP_W'(7);
          6'h2A: d_alu_op = ALUOP_W'(8);
          6'h08: begin d_reg_write = 1'b0; d_pcsrc = PCSRC_W'(1); end
          default: d_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin d_alu_op = ALUOP_W'(0); d_alu_src = 1'b1; d_reg_write = 1'b1; d_dest = id_rt; end
      6'h0A: begin d_alu_op = ALUOP_W'(8); d_alu_src = 1'b1; d_reg_write = 1'b1; d_dest = id_rt; end
      6'h0C: begin d_alu_op = ALUOP_W'(2); d_alu_src = 1'b1; d_reg_write = 1'b1; d_dest = id_rt; end
      6'h0D: begin d_alu_op = ALUOP_W'(3); d_alu_src = 1'b1; d_reg_write = 1'b1; d_dest = id_rt; end
      6'h0F: begin d_alu_op = ALUOP_W'(9); d_alu_src = 1'b1; d_reg_write = 1'b1; d_dest = id_rt; end
      6'h04: begin d_alu_op = ALUOP_W'(13); d_pcsrc = PCSRC_W'(2); end
      6'h05: begin d_alu_op = ALUOP_W'(10); d_pcsrc = PCSRC_W'(2); end
      6'h07: begin d_alu_op = ALUOP_W'(11); d_pcsrc = PCSRC_W'(2); end
      6'h01: begin d_alu_op = ALUOP_W'(12); d_pcsrc = PCSRC_W'(2); end
      6'h23: begin
        d_alu_op = ALUOP_W'(14); d_alu_src = 1'b1; d_mem_read = 1'b1;
        d_reg_write = 1'b1; d_mem_to_reg = 1'b1; d_dest = id_rt;
      end
      6'h2B: begin d_alu_op = ALUOP_W'(14); d_alu_src = 1'b1; d_mem_write = 1'b1; end
      6'h02: d_pcsrc = PCSRC_W'(3);
      6'h03: begin d_pcsrc = PCSRC_W'(7); d_reg_write = 1'b1; d_dest = RADDR_W'(31); end
      default: d_legal = 1'b0;
    endcase
    // Empty slots and undecodable instructions travel as bubbles; d_legal survives for the sticky flag
    if (!(id_valid && d_legal)) begin
      d_alu_op = '0; d_alu_src = 1'b0; d_pcsrc = '0; d_mem_read = 1'b0; d_mem_write = 1'b0;
      d_reg_write = 1'b0; d_mem_to_reg = 1'b0; d_dest = '0;
    end
    if (d_dest == '0) d_reg_write = 1'b0;
  end

  function automatic logic src_hit(input logic [RADDR_W-1:0] d,
                                   input logic [RADDR_W-1:0] rs, input logic [RADDR_W-1:0] rt);
    return (d != '0) && ((d == rs) || (d == rt));
  endfunction

`ifdef PIPE_CTRL_FWD_EN
  logic [RADDR_W-1:0] rs_p0, rt_p0;
  logic vld_p2;

  assign hazard = id_valid && vld_p0 && mr_p0 && src_hit(dest_p0, id_rs, id_rt);

  function automatic logic [1:0] fwd_sel(input logic [RADDR_W-1:0] src,
      input logic v1, input logic w1, input logic [RADDR_W-1:0] d1,
      input logic v2, input logic w2, input logic [RADDR_W-1:0] d2);
    if (src == '0) return 2'b00;
    if (v1 && w1 && d1 == src) return 2'b10;
    if (v2 && w2 && d2 == src) return 2'b01;
    return 2'b00;
  endfunction

  assign ex_fwd_a = fwd_sel(rs_p0, vld_p1, rw_p1, dest_p1, vld_p2, rw_p2, dest_p2);
  assign ex_fwd_b = fwd_sel(rt_p0, vld_p1, rw_p1, dest_p1, vld_p2, rw_p2, dest_p2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_p0 <= '0; rt_p0 <= '0; vld_p2 <= 1'b0;
    end else begin
      rs_p0  <= bubble_in ? '0 : id_rs;
      rt_p0  <= bubble_in ? '0 : id_rt;
      vld_p2 <= vld_p1;
    end
  end
`else
  // Regfile writes in the first half-cycle, so only ID/EX and EX/MEM producers need a stall
  assign hazard = id_valid && ((vld_p0 && rw_p0 && src_hit(dest_p0, id_rs, id_rt)) ||
                               (vld_p1 && rw_p1 && src_hit(dest_p1, id_rs, id_rt)));
  assign ex_fwd_a = 2'b00;
  assign ex_fwd_b = 2'b00;
`endif

  assign redirect      = ex_redirect && !rst;
  assign stall         = hazard && !ex_redirect && !rst;
  assign bubble_in     = stall || redirect;
  assign pc_write_en   = !stall;
  assign ifid_write_en = !stall;
  assign ifid_flush    = redirect;

  // ID/EX, EX/MEM, MEM/WB registers and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0; alu_op_p0 <= '0; alu_src_p0 <= 1'b0; pcsrc_p0 <= '0;
      mr_p0 <= 1'b0; mw_p0 <= 1'b0; rw_p0 <= 1'b0; m2r_p0 <= 1'b0; dest_p0 <= '0;
      vld_p1 <= 1'b0; mr_p1 <= 1'b0; mw_p1 <= 1'b0; rw_p1 <= 1'b0; m2r_p1 <= 1'b0; dest_p1 <= '0;
      rw_p2 <= 1'b0; m2r_p2 <= 1'b0; dest_p2 <= '0;
      illegal_instr <= 1'b0; stall_count <= '0; flush_count <= '0;
    end else begin
      if (bubble_in) begin
        vld_p0 <= 1'b0; alu_op_p0 <= '0; alu_src_p0 <= 1'b0; pcsrc_p0 <= '0;
        mr_p0 <= 1'b0; mw_p0 <= 1'b0; rw_p0 <= 1'b0; m2r_p0 <= 1'b0; dest_p0 <= '0;
      end else begin
        vld_p0 <= id_valid && d_legal; alu_op_p0 <= d_alu_op; alu_src_p0 <= d_alu_src;
        pcsrc_p0 <= d_pcsrc; mr_p0 <= d_mem_read; mw_p0 <= d_mem_write;
        rw_p0 <= d_reg_write; m2r_p0 <= d_mem_to_reg; dest_p0 <= d_dest;
      end
      vld_p1 <= vld_p0; mr_p1 <= mr_p0; mw_p1 <= mw_p0; rw_p1 <= rw_p0; m2r_p1 <= m2r_p0;
      dest_p1 <= dest_p0;
      rw_p2 <= rw_p1; m2r_p2 <= m2r_p1; dest_p2 <= dest_p1;
      if (id_valid && !d_legal) illegal_instr <= 1'b1;
      if (stall)    stall_count <= sat_inc(stall_count);
      if (redirect) flush_count <= sat_inc(flush_count);
    end
  end

  assign ex_alu_op     = alu_op_p0;
  assign ex_alu_src    = alu_src_p0;
  assign ex_pcsrc      = pcsrc_p0;
  assign mem_read      = mr_p1;
  assign mem_write     = mw_p1;
  assign wb_reg_write  = rw_p2;
  assign wb_mem_to_reg = m2r_p2;
  assign wb_dest       = dest_p2;

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the five-stage processor: decodes opcode/funcode in ID, carries control bundles through the ID/EX, EX/MEM and MEM/WB registers, detects load-use and RAW hazards, generates stall/flush and forwarding selects, and keeps saturating stall/flush counters. It replaces the purely combinational decoder. The datapath consumes its per-stage control outputs directly.

## Interface
- ALUOP_W, 5, ALU opcode width (min 5)
- PCSRC_W, 4, PC source select width (min 3)
- RADDR_W, 5, register address width
- CNT_W, 16, perf counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode, id_funcode  in  6 each  instruction fields in ID
- id_rs, id_rt, id_rd  in  RADDR_W each  register fields in ID
- ex_redirect  in  1  EX resolved taken branch/jump; younger instructions must die
- pc_write_en, ifid_write_en  out  1 each  low = hold PC / IF/ID
- ifid_flush  out  1  zero IF/ID next edge
- ex_alu_op  out  ALUOP_W; ex_alu_src, ex_pcsrc (PCSRC_W)  out  EX-stage control
- ex_fwd_a, ex_fwd_b  out  2 each  operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- mem_read, mem_write  out  1 each  MEM-stage control
- wb_reg_write, wb_mem_to_reg  out  1 each; wb_dest  out  RADDR_W
- illegal_instr  out  1  sticky, set by undecodable valid instruction
- stall_count, flush_count  out  CNT_W each  saturating

## Operation
- ALU codes: add 0, sub 1, and 2, or 3, nor 4, sll 5, srl 6, sra 7, slt 8, lui 9, bne 10, bgtz 11, bgez 12, beq 13, mem_add 14; zero-extended to ALUOP_W.
- PCsrc: 0 seq, 1 jr, 2 branch, 3 j, 7 jal.
- Decode set: R-type add/addu/sub/subu/and/or/nor/slt/sll/srl/sra/jr; andi, ori, slti, addi, addiu, beq, bne, bgtz, bgez, lw, sw, lui, j, jal. I-type ALU ops and lw/sw use ALUsrc=1, dest=rt; R-type dest=rd; jal RegWrite=1, dest=31; branches, j, jr, sw RegWrite=0.
- Unknown opcode or unknown R-type funcode with id_valid=1: bubble (all write/read enables 0, pcsrc 0) and set illegal_instr until rst.
- id_valid=0: bubble, illegal_instr unaffected.
- Writes to register 0 are suppressed: RegWrite forced 0 when dest=0.
- Load-use: ID/EX MemRead=1 and ID/EX dest≠0 equals id_rs or id_rt -> pc_write_en=0, ifid_write_en=0, bubble into ID/EX for one cycle.
- Forwarding (EX operand rs/rt held in ID/EX): EX/MEM RegWrite and dest match -> 10; else MEM/WB RegWrite and dest match -> 01; else 00. EX/MEM wins when both match. Never forward for register 0.
- ex_redirect=1: bubble into ID/EX, ifid_flush=1, pc_write_en=1. Redirect overrides a simultaneous stall; no stall counted that cycle.
- stall_count +1 per stall cycle, flush_count +1 per redirect cycle; both hold at all-ones.

## Timing
- Decode and hazard/forward logic combinational in ID/EX; pipeline registers update on clk rise.
- Control reaches EX 1 cycle after ID, MEM 2, WB 3.
- Reset: all pipeline registers bubble; pc_write_en=1, ifid_write_en=1, ifid_flush=0, fwd selects 00, all control outputs 0, wb_dest 0, illegal_instr 0, counters 0. Reset mid-stall clears stall immediately (asynchronous).
- Stall and redirect are single-cycle per assertion; back-to-back lw-dependent pairs stall one cycle each.

## Configuration
- PIPE_CTRL_FWD_EN defined: forwarding as above; only load-use stalls.
- Undefined: ex_fwd_a/ex_fwd_b tied 00; stall whenever id_rs/id_rt (≠0) matches dest of an ID/EX or EX/MEM instruction with RegWrite=1 (regfile writes first half-cycle, so MEM/WB needs no stall). Stall rules and counters otherwise identical.

## Test plan
- Reset mid-run with rst=1 -> all outputs at reset values same cycle; counters 0; pc_write_en=1.
- addi $1 then add $2,$1,$1 (FWD_EN) -> ex_fwd_a=ex_fwd_b=10 for add, no stall; without FWD_EN -> 2 stall cycles, stall_count=2.
- lw $3 then sub $4,$3,$5 -> one cycle pc_write_en=0, ID/EX bubble, then ex_fwd_a=01; stall_count=1.
- ex_redirect=1 while load-use hazard present -> ifid_flush=1, pc_write_en=1, stall_count unchanged, flush_count +1.
- jal -> wb_reg_write=1, wb_dest=31 three cycles later; addi $0 -> wb_reg_write=0.
- opcode 6'b111111 valid -> bubble, illegal_instr=1 and held after subsequent legal instructions; counters saturate at 16'hFFFF under forced continuous redirect.
